// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine with internal operand skew,
// start/done job control, valid/ready operand streaming and a backpressured row drain.
// Optional macro SYSTOLIC_ARRAY_OS_SAT_EN: saturating accumulators plus a sticky sat_flag output.
module systolic_array_os #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [K_WIDTH-1:0]           k_len,
  output logic                         busy,
  output logic                         done,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]   a_in,
  input  logic [COLS*DATA_WIDTH-1:0]   w_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(ROWS)-1:0]      out_row,
  output logic [COLS*ACC_WIDTH-1:0]    out_data,
  output logic                         out_last
`ifdef SYSTOLIC_ARRAY_OS_SAT_EN
  ,
  output logic                         sat_flag
`endif
);

  localparam int RW         = $clog2(ROWS);
  localparam int FW         = $clog2(ROWS + COLS);
  localparam int FLUSH_LAST = ROWS + COLS - 2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t                         r_state;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_in_ready;
  logic                           r_out_valid;
  logic                           r_out_last;
  logic [RW-1:0]                  r_out_row;
  logic [K_WIDTH-1:0]             r_k_len;
  logic [K_WIDTH-1:0]             r_cnt;
  logic [FW-1:0]                  r_fcnt;
  logic signed [ACC_WIDTH-1:0]    r_out_data [COLS];

  logic signed [DATA_WIDTH-1:0]   r_pa  [ROWS][COLS-1];
  logic signed [DATA_WIDTH-1:0]   r_pw  [ROWS-1][COLS];
  logic signed [ACC_WIDTH-1:0]    r_acc [ROWS][COLS];

  logic signed [DATA_WIDTH-1:0]   w_a_edge [ROWS];
  logic signed [DATA_WIDTH-1:0]   w_w_edge [COLS];
  logic signed [DATA_WIDTH-1:0]   w_a_op   [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]   w_w_op   [ROWS][COLS];

  logic                           w_clear;
  logic                           w_accept;
  logic                           w_acc_en;
  logic [K_WIDTH-1:0]             w_cnt_nxt;
  logic [RW-1:0]                  w_row_nxt;

  assign w_clear   = (r_state == S_IDLE) && start && (k_len != '0);
  assign w_accept  = (r_state == S_LOAD) && in_valid;
  assign w_acc_en  = (r_state == S_LOAD) || (r_state == S_FLUSH);
  assign w_cnt_nxt = r_cnt + K_WIDTH'(1);
  assign w_row_nxt = r_out_row + RW'(1);

  // Full-precision product, sign-extended one bit beyond the accumulator to expose overflow.
  function automatic logic signed [ACC_WIDTH:0] f_wide_sum(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] w
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(w);
    f_wide_sum = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(prod);
  endfunction

`ifdef SYSTOLIC_ARRAY_OS_SAT_EN
  function automatic logic f_ovf(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] w
  );
    logic signed [ACC_WIDTH:0] sum;
    sum   = f_wide_sum(acc, a, w);
    f_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] f_mac(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] w
  );
    logic signed [ACC_WIDTH:0] sum;
    sum = f_wide_sum(acc, a, w);
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
      f_mac = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      f_mac = sum[ACC_WIDTH-1:0];
  endfunction
`else
  function automatic logic signed [ACC_WIDTH-1:0] f_mac(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] w
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    prod  = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(w);
    f_mac = acc + ACC_WIDTH'(prod);
  endfunction
`endif

  // Skew front: row r / column c sees its operand r / c cycles after row 0 / column 0.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_askew
    logic signed [DATA_WIDTH-1:0] r_sh [gr+1];
    always_ff @(posedge clk) begin
      if (rst || w_clear) begin
        for (int i = 0; i <= gr; i++) r_sh[i] <= '0;
      end else begin
        r_sh[0] <= w_accept ? $signed(a_in[gr*DATA_WIDTH +: DATA_WIDTH]) : '0;
        for (int i = 1; i <= gr; i++) r_sh[i] <= r_sh[i-1];
      end
    end
    assign w_a_edge[gr] = r_sh[gr];
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_wskew
    logic signed [DATA_WIDTH-1:0] r_sh [gc+1];
    always_ff @(posedge clk) begin
      if (rst || w_clear) begin
        for (int i = 0; i <= gc; i++) r_sh[i] <= '0;
      end else begin
        r_sh[0] <= w_accept ? $signed(w_in[gc*DATA_WIDTH +: DATA_WIDTH]) : '0;
        for (int i = 1; i <= gc; i++) r_sh[i] <= r_sh[i-1];
      end
    end
    assign w_w_edge[gc] = r_sh[gc];
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      w_a_op[r][0] = w_a_edge[r];
      for (int c = 1; c < COLS; c++) w_a_op[r][c] = r_pa[r][c-1];
    end
    for (int c = 0; c < COLS; c++) begin
      w_w_op[0][c] = w_w_edge[c];
      for (int r = 1; r < ROWS; r++) w_w_op[r][c] = r_pw[r-1][c];
    end
  end

  // ---- PE array: operands hop one PE per cycle, accumulators stay put ----
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) r_acc[r][c] <= '0;
        for (int c = 0; c < COLS-1; c++) r_pa[r][c] <= '0;
      end
      for (int r = 0; r < ROWS-1; r++)
        for (int c = 0; c < COLS; c++) r_pw[r][c] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS-1; c++) r_pa[r][c] <= w_a_op[r][c];
      for (int r = 0; r < ROWS-1; r++)
        for (int c = 0; c < COLS; c++) r_pw[r][c] <= w_w_op[r][c];
      if (w_acc_en) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            r_acc[r][c] <= f_mac(r_acc[r][c], w_a_op[r][c], w_w_op[r][c]);
      end
    end
  end

`ifdef SYSTOLIC_ARRAY_OS_SAT_EN
  logic [ROWS*COLS-1:0] w_sat_hit;
  logic                 r_sat_flag;

  always_comb begin
    w_sat_hit = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        w_sat_hit[r*COLS + c] = f_ovf(r_acc[r][c], w_a_op[r][c], w_w_op[r][c]);
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear)            r_sat_flag <= 1'b0;
    else if (w_acc_en && |w_sat_hit) r_sat_flag <= 1'b1;
  end

  assign sat_flag = r_sat_flag;
`endif

  // ---- Job control FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_row   <= '0;
      r_k_len     <= '0;
      r_cnt       <= '0;
      r_fcnt      <= '0;
      for (int c = 0; c < COLS; c++) r_out_data[c] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              r_k_len    <= k_len;
              r_cnt      <= '0;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
              r_state    <= S_LOAD;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_k_len) begin
              r_in_ready <= 1'b0;
              r_fcnt     <= '0;
              r_state    <= S_FLUSH;
            end
          end
        end
        // Wait until the last operand has crossed to the far corner PE.
        S_FLUSH: begin
          if (r_fcnt == FW'(FLUSH_LAST)) begin
            r_state     <= S_DRAIN;
            r_out_valid <= 1'b1;
            r_out_row   <= '0;
            r_out_last  <= 1'b0;
            for (int c = 0; c < COLS; c++) r_out_data[c] <= r_acc[0][c];
          end else begin
            r_fcnt <= r_fcnt + FW'(1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_row   <= '0;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_out_row  <= w_row_nxt;
              r_out_last <= (w_row_nxt == RW'(ROWS-1));
              for (int c = 0; c < COLS; c++) r_out_data[c] <= r_acc[w_row_nxt][c];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;
  assign out_last  = r_out_last;

  for (genvar gc = 0; gc < COLS; gc++) begin : g_out
    assign out_data[gc*ACC_WIDTH +: ACC_WIDTH] = r_out_data[gc];
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed self-checking bench for systolic_array_os (4x4, 8-bit operands, 16-bit accumulators).
// Covers identity, signed extremes with bubbles, backpressure, zero-length job, mid-job reset, overflow.
module tb_systolic_array_os;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int KW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            in_valid;
  logic            in_ready;
  logic [R*DW-1:0] a_in;
  logic [C*DW-1:0] w_in;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_row;
  logic [C*AW-1:0] out_data;
  logic            out_last;
`ifdef SYSTOLIC_ARRAY_OS_SAT_EN
  logic            sat_flag;
`endif

  always #5 clk = ~clk;

  systolic_array_os #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .out_last(out_last)
`ifdef SYSTOLIC_ARRAY_OS_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int va [8][R];
  int vw [8][C];
  int exp_c [R][C];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int idx);
    for (int r = 0; r < R; r++) a_in[r*DW +: DW] = DW'(va[idx][r]);
    for (int c = 0; c < C; c++) w_in[c*DW +: DW] = DW'(vw[idx][c]);
  endtask

  task automatic load_identity();
    for (int k = 0; k < R; k++) begin
      for (int r = 0; r < R; r++) va[k][r] = (r == k) ? 1 : 0;
      for (int c = 0; c < C; c++) vw[k][c] = k*4 + c + 1;
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) exp_c[r][c] = r*4 + c + 1;
  endtask

  task automatic load_signed();
    for (int r = 0; r < R; r++) begin va[0][r] = -128; va[1][r] = 127; end
    for (int c = 0; c < C; c++) begin vw[0][c] = -128; vw[1][c] = 127; end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) exp_c[r][c] = 32513;
  endtask

  task automatic load_sat();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < R; r++) va[k][r] = -128;
      for (int c = 0; c < C; c++) vw[k][c] = -128;
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
`ifdef SYSTOLIC_ARRAY_OS_SAT_EN
        exp_c[r][c] = 32767;
`else
        exp_c[r][c] = -16384;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},      busy,      0);
    check_eq({tag, "_done"},      done,      0);
    check_eq({tag, "_in_ready"},  in_ready,  0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_row"},   out_row,   0);
    check_eq({tag, "_out_data"},  out_data,  0);
    check_eq({tag, "_out_last"},  out_last,  0);
`ifdef SYSTOLIC_ARRAY_OS_SAT_EN
    check_eq({tag, "_sat_flag"},  sat_flag,  0);
`endif
  endtask

  // Called at a negedge; cycle 0 is the cycle in which start is presented.
  task automatic run_job(input string tag, input int k, input bit bubbles, input int bp_row,
                         input int t_first, input int t_done);
    int cyc, idx, row, hold, guard;
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk); cyc = 1;
    start = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
    idx = 0;
    while (idx < k && cyc < 200) begin
      check_eq({tag, "_in_ready"}, in_ready, 1);
      in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid) set_vec(idx);
      else begin a_in = 32'($urandom); w_in = 32'($urandom); end
      @(negedge clk); cyc++;
      if (in_valid) idx++;
    end
    in_valid = 1'b0;
    check_eq({tag, "_in_ready_drop"}, in_ready, 0);
    while (!out_valid && cyc < 200) begin @(negedge clk); cyc++; end
    check_eq({tag, "_first_valid"}, out_valid, 1);
    if (t_first >= 0) check_eq({tag, "_first_cycle"}, cyc, t_first);
    row = 0; hold = 0; guard = 0;
    while (row < R && guard < 60) begin
      check_eq({tag, "_valid"}, out_valid, 1);
      check_eq({tag, "_row"}, out_row, row);
      check_eq({tag, "_last"}, out_last, (row == R-1));
      check_eq({tag, "_no_early_done"}, done, 0);
      for (int c = 0; c < C; c++)
        check_eq($sformatf("%s_r%0dc%0d", tag, row, c), $signed(out_data[c*AW +: AW]), exp_c[row][c]);
      if (row == bp_row && hold < 5) begin out_ready = 1'b0; hold++; end
      else begin out_ready = 1'b1; row++; end
      @(negedge clk); cyc++; guard++;
    end
    out_ready = 1'b0;
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy_clr"}, busy, 0);
    check_eq({tag, "_valid_clr"}, out_valid, 0);
    if (t_done >= 0) check_eq({tag, "_done_cycle"}, cyc, t_done);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_no_extra_row"}, out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int saw_done, saw_valid;
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; w_in = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    load_identity();
    run_job("ident", 4, 1'b0, -1, 12, 16);
`ifdef SYSTOLIC_ARRAY_OS_SAT_EN
    check_eq("ident_sat_flag", sat_flag, 0);
`endif

    load_signed();
    run_job("sgn", 2, 1'b0, -1, 10, 14);
    run_job("sgn_bub", 2, 1'b1, -1, -1, -1);

    load_identity();
    run_job("bp", 4, 1'b0, 1, 12, 21);

    start = 1'b1; k_len = '0;
    @(negedge clk);
    start = 1'b0;
    check_eq("k0_done", done, 1);
    check_eq("k0_busy", busy, 0);
    check_eq("k0_in_ready", in_ready, 0);
    check_eq("k0_out_valid", out_valid, 0);
    @(negedge clk);
    check_eq("k0_done_pulse", done, 0);
    check_eq("k0_in_ready2", in_ready, 0);
    check_eq("k0_out_valid2", out_valid, 0);

    // Abort a job partway through FLUSH.
    load_identity();
    start = 1'b1; k_len = KW'(4);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; set_vec(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b0;
    saw_done = 0; saw_valid = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (out_valid) saw_valid = 1;
    end
    check_eq("abort_no_done", saw_done, 0);
    check_eq("abort_no_valid", saw_valid, 0);
    load_signed();
    run_job("post_abort", 2, 1'b0, -1, 10, 14);

    load_sat();
    run_job("ovf", 3, 1'b0, -1, 11, 15);
`ifdef SYSTOLIC_ARRAY_OS_SAT_EN
    check_eq("ovf_sat_flag", sat_flag, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array_os.md
Name: systolic_array_os

Overview:
- Parametrised ROWS x COLS output-stationary systolic matrix-multiply engine; successor to the fixed 4x4 array.
- Computes C[ROWS][COLS] = sum over k of A[r][k]*W[k][c].
- Adds internal input skewing, a start/done job handshake, valid/ready operand streaming and a backpressured row-by-row result drain.
- Sits between the operand buffers and the activation/writeback stage.

Parameters:
- ROWS, 4, array rows (>=2)
- COLS, 4, array columns (>=2)
- DATA_WIDTH, 8, signed operand width
- ACC_WIDTH, 32, signed accumulator width (>= 2*DATA_WIDTH)
- K_WIDTH, 16, width of reduction-length field

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  job request, sampled only in IDLE
- k_len  in  K_WIDTH  reduction length, sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job end
- in_valid  in  1  operand vector valid
- in_ready  out  1  high only in LOAD
- a_in  in  ROWS*DATA_WIDTH  column k of A; row r at bits [r*DATA_WIDTH +: DATA_WIDTH]
- w_in  in  COLS*DATA_WIDTH  row k of W; column c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts row
- out_row  out  $clog2(ROWS)  index of the presented row
- out_data  out  COLS*ACC_WIDTH  accumulators of row out_row; column c at [c*ACC_WIDTH +: ACC_WIDTH]
- out_last  out  1  high with the final row

Behaviour:
- Clock is clk. Reset is rst, synchronous, active-high.
- On reset, every output is 0: busy, done, in_ready, out_valid, out_row, out_data, out_last. In addition, the FSM returns to IDLE and all PE data registers, accumulators, skew registers and counters clear. Reset mid-job aborts the job with no done pulse.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - start=1 and k_len!=0: latch k_len, clear all accumulators and skew/PE data registers, enter LOAD next cycle, busy=1.
  - start=1 and k_len==0: no state change; done pulses the next cycle with busy held 0; no output rows.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1 accepts one vector and increments the accepted count.
  - Cycles with in_valid=0 inject zeros into the skew front. Bubbles are legal and the result is unchanged.
  - After k_len vectors are accepted, the next state is FLUSH. in_ready drops in the cycle after the last acceptance.
- Skew:
  - Row r activation is delayed r cycles; column c weight is delayed c cycles (shift registers, zero-filled).
- PE(r,c), per cycle:
  - acc += sext(a*w) (full 2*DATA_WIDTH signed product).
  - a passes right and w passes down through one register each.
  - Accumulation wraps modulo 2^ACC_WIDTH.
- FLUSH:
  - Lasts exactly ROWS+COLS-1 cycles, counting zeros, so the last operand reaches PE(ROWS-1,COLS-1) and is accumulated. Then DRAIN.
- DRAIN:
  - out_valid=1 and out_row starts at 0. out_data is the registered accumulators of row out_row.
  - On out_valid&&out_ready, out_row increments.
  - While out_ready=0, out_row, out_data and out_last are held stable.
  - out_last=1 when out_row==ROWS-1.
  - Handshake on the last row: out_valid=0 and done=1 for one cycle, busy=0, state IDLE.
- start asserted while busy=1 is ignored.
- Latency with ROWS=COLS=4, K=4 and no bubbles or backpressure: start accepted at cycle 0, LOAD cycles 1-4, FLUSH cycles 5-11, first out_valid at cycle 12, done at cycle 16.
- Accumulators are not cleared after drain; they clear only on the next accepted start.

Optional Feature:
- SYSTOLIC_ARRAY_OS_SAT_EN defined:
  - Each accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] instead of wrapping.
  - A sticky per-job output sat_flag (1 bit, reset 0) is added. It is cleared on accepted start and set if any PE saturates.
- Undefined: wrapping arithmetic and no sat_flag port.

Test Plan:
- Identity: 4x4, k_len=4, A=I, W[k][c]=k*4+c+1, no bubbles. Rows 0..3 read {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}. out_valid at cycle 12, done at cycle 16.
- Signed/bubbles: k_len=2, A column0 all -128, column1 all 127, W rows all -128 and 127. Every acc = 16384+16129 = 32513. Random in_valid gaps give the identical result.
- Backpressure: out_ready low for 5 cycles on row 1. out_row=1 and out_data are stable throughout. Exactly 4 handshakes occur, out_last only on row 3.
- k_len=0 start: no LOAD, in_ready stays 0, done pulses next cycle, out_valid never asserts.
- Reset mid-job: assert rst during FLUSH. All outputs are 0 next cycle, no done. A new job then gives a correct result with no residue.
- With SYSTOLIC_ARRAY_OS_SAT_EN and ACC_WIDTH=16, k_len=3, all operands -128: acc = 32767, sat_flag=1. Without the macro: acc wraps to 49152 mod 65536, i.e. -16384.
